triangle_list_reader: RTL

- Frame-level fetch engine on the read side of the on-chip triangle list RAM.
- On a start pulse it walks addresses 0..N-1 and drives the RAM read port (1-cycle registered read latency).
- Absorbs that latency with a 2-entry skid buffer and delivers packed triangles to the transform/raster pipeline over a valid/ready handshake.
- Pulses done once the last triangle has been accepted downstream.

---
 rtl/triangle_list_reader_if.sv | 39 +++
 rtl/triangle_list_reader.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/triangle_list_reader_if.sv
// Read-side bus bundle for triangle_list_reader.
// Carries the triangle list RAM read port and the packed-triangle valid/ready
// stream toward the transform/raster pipeline.
//   master : the reader. It drives the RAM read controls and the triangle stream.
//   slave  : the RAM plus the downstream pipeline. It drives ram_data and tri_ready.
interface triangle_list_reader_if #(
  parameter int unsigned WI    = 8,
  parameter int unsigned WF    = 8,
  parameter int unsigned Waddr = 7
);
  localparam int unsigned DW = (WI + WF) * 9;

  // RAM read port
  logic             ram_r_en;
  logic [Waddr-1:0] ram_r_addr;
  logic             ram_is_empty;
  logic [DW-1:0]    ram_data;

  // Triangle stream
  logic             tri_valid;
  logic             tri_ready;
  logic [DW-1:0]    tri_data;
  logic [Waddr-1:0] tri_index;
  logic             tri_last;

  modport master (
    output ram_r_en, ram_r_addr, ram_is_empty,
    input  ram_data,
    output tri_valid, tri_data, tri_index, tri_last,
    input  tri_ready
  );

  modport slave (
    input  ram_r_en, ram_r_addr, ram_is_empty,
    output ram_data,
    input  tri_valid, tri_data, tri_index, tri_last,
    output tri_ready
  );
endinterface

// File: rtl/triangle_list_reader.sv
// Frame-level fetch engine for the triangle list RAM.
// A start pulse walks addresses 0..N-1 (N = min(tri_count, size+1)). The RAM
// has one cycle of registered read latency, which a 2-entry skid buffer
// absorbs. The buffer presents triangles in order on a valid/ready stream.
// done pulses once after the last triangle has been accepted.
// Ports:
//   Clk, Reset     : clock and synchronous active-high reset
//   start          : one-cycle frame request, ignored while busy
//   tri_count      : triangles in the frame, sampled when start is accepted
//   busy           : FSM not idle
//   done           : one-cycle frame-complete pulse
//   bus (master)   : RAM read port plus the triangle valid/ready stream
module triangle_list_reader #(
  parameter int unsigned WI    = 8,
  parameter int unsigned WF    = 8,
  parameter int unsigned Waddr = 7,
  parameter int unsigned size  = 100
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  start,
  input  logic [Waddr-1:0]      tri_count,
  output logic                  busy,
  output logic                  done,
  triangle_list_reader_if.master bus
);

  localparam int unsigned DW = (WI + WF) * 9;
  localparam int unsigned CW = Waddr + 1;  // counts up to size+1 inclusive
  localparam logic [CW-1:0] MAX_N = CW'(size + 1);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

  typedef struct packed {
    logic [DW-1:0]    data;
    logic [Waddr-1:0] index;
    logic             last;
  } entry_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    n_q, n_d;
  logic [Waddr-1:0] rd_addr_q, rd_addr_d;
  logic [CW-1:0]    pop_cnt_q, pop_cnt_d;
  logic             inflight_q, inflight_d;
  logic [Waddr-1:0] infl_index_q, infl_index_d;
  logic             infl_last_q, infl_last_d;
  entry_t           head_q, head_d;
  entry_t           tail_q, tail_d;
  logic             head_v_q, head_v_d;
  logic             tail_v_q, tail_v_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             empty_q, empty_d;

  logic             pop_c;
  logic             issue_c;
  logic             rd_is_last_c;
  logic [2:0]       pending_c;
  logic [CW-1:0]    n_start_c;
  entry_t           new_c;

  // Entries held or already requested once this cycle's pop is taken out.
  assign pop_c     = head_v_q & bus.tri_ready;
  assign pending_c = {2'b00, head_v_q} + {2'b00, tail_v_q}
                   + {2'b00, inflight_q} - {2'b00, pop_c};

  assign rd_is_last_c = (CW'(rd_addr_q) == n_q - CW'(1));
  assign issue_c      = (state_q == FETCH) && (CW'(rd_addr_q) < n_q)
                      && (pending_c < 3'd2);

  // Frame length clamped to the RAM depth.
  assign n_start_c = (CW'(tri_count) > CW'(size)) ? MAX_N : CW'(tri_count);

  // Next state, counters and skid buffer
  always_comb begin
    state_d      = state_q;
    n_d          = n_q;
    rd_addr_d    = rd_addr_q;
    pop_cnt_d    = pop_cnt_q;
    inflight_d   = issue_c;
    infl_index_d = infl_index_q;
    infl_last_d  = infl_last_q;
    head_d       = head_q;
    tail_d       = tail_q;
    head_v_d     = head_v_q;
    tail_v_d     = tail_v_q;
    done_d       = 1'b0;
    new_c.data   = bus.ram_data;
    new_c.index  = infl_index_q;
    new_c.last   = infl_last_q;

    if (pop_c) begin
      pop_cnt_d = pop_cnt_q + CW'(1);
    end

    if (issue_c) begin
      infl_index_d = rd_addr_q;
      infl_last_d  = rd_is_last_c;
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          n_d       = n_start_c;
          rd_addr_d = '0;
          pop_cnt_d = '0;
          state_d   = (n_start_c == '0) ? DONE : FETCH;
        end
      end
      FETCH: begin
        // Address holds at N-1 after the final read so it never leaves the list.
        if (issue_c) begin
          if (rd_is_last_c) begin
            state_d = DRAIN;
          end else begin
            rd_addr_d = rd_addr_q + Waddr'(1);
          end
        end
      end
      DRAIN: begin
        if (pop_c && (pop_cnt_q == n_q - CW'(1))) begin
          state_d = DONE;
        end
      end
      DONE: begin
        // First DONE cycle arms the pulse; second cycle shows it and exits.
        if (done_q) begin
          state_d   = IDLE;
          rd_addr_d = '0;
        end else begin
          done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Pop shifts the tail forward, then the returning RAM word fills the
    // first free slot. Flow control keeps a push from ever meeting a full buffer.
    if (pop_c) begin
      if (tail_v_q) begin
        head_d   = tail_q;
        tail_v_d = 1'b0;
      end else begin
        head_v_d = 1'b0;
      end
    end
    if (inflight_q) begin
      if (!head_v_d) begin
        head_d   = new_c;
        head_v_d = 1'b1;
      end else begin
        tail_d   = new_c;
        tail_v_d = 1'b1;
      end
    end

    busy_d  = (state_d != IDLE);
    empty_d = (state_d == IDLE) || (state_d == DONE);
  end

  // State and output registers
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= IDLE;
      n_q          <= '0;
      rd_addr_q    <= '0;
      pop_cnt_q    <= '0;
      inflight_q   <= 1'b0;
      infl_index_q <= '0;
      infl_last_q  <= 1'b0;
      head_q       <= '0;
      tail_q       <= '0;
      head_v_q     <= 1'b0;
      tail_v_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      empty_q      <= 1'b1;
    end else begin
      state_q      <= state_d;
      n_q          <= n_d;
      rd_addr_q    <= rd_addr_d;
      pop_cnt_q    <= pop_cnt_d;
      inflight_q   <= inflight_d;
      infl_index_q <= infl_index_d;
      infl_last_q  <= infl_last_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      head_v_q     <= head_v_d;
      tail_v_q     <= tail_v_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      empty_q      <= empty_d;
    end
  end

  assign bus.ram_r_en     = issue_c;
  assign bus.ram_r_addr   = rd_addr_q;
  assign bus.ram_is_empty = empty_q;
  assign bus.tri_valid    = head_v_q;
  assign bus.tri_data     = head_q.data;
  assign bus.tri_index    = head_q.index;
  assign bus.tri_last     = head_q.last;
  assign busy             = busy_q;
  assign done             = done_q;

endmodule
